// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter side bundle for uart_tx_queue: two write ports,
// the uart_tx handshake, and queue status.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_a_en;
    logic [7:0]    wr_a_data;
    logic          wr_b_en;
    logic [7:0]    wr_b_data;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_done;
    logic          clr_ovf;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          timeout;

    modport master (
        output wr_a_en, wr_a_data, wr_b_en, wr_b_data, tx_done, clr_ovf,
        input  tx_data, tx_en, level, empty, full, overflow, timeout
    );

    modport slave (
        input  wr_a_en, wr_a_data, wr_b_en, wr_b_data, tx_done, clr_ovf,
        output tx_data, tx_en, level, empty, full, overflow, timeout
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Dual-write circular byte FIFO feeding uart_tx one byte at a time: enable
// pulse, then wait for the tx_done rising edge or give up after TIMEOUT cycles.
module uart_tx_queue #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] level, free;
    logic [CW-1:0] cnt;
    logic [7:0]    tx_data;
    logic          tx_en, done_q, overflow, timeout;
    logic          a_ok, b_ok, drop, pop, done_rise, cnt_max, tmo_hit;

    // Space is judged on the level at the start of the cycle; a same-cycle
    // pop does not make room for this cycle's writes.
    always_comb begin
        free      = LW'(DEPTH) - level;
        a_ok      = bus.wr_a_en && (free != '0);
        b_ok      = bus.wr_b_en && (bus.wr_a_en ? (free >= LW'(2)) : (free != '0));
        drop      = (bus.wr_a_en && !a_ok) || (bus.wr_b_en && !b_ok);
        pop       = (state == IDLE) && (level != '0);
        done_rise = bus.tx_done && !done_q;
        cnt_max   = (cnt == CW'(TIMEOUT - 1));
        tmo_hit   = (state == WAIT) && !done_rise && cnt_max;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = SEND;
            SEND:    state_nx = WAIT;
            WAIT:    if (done_rise || cnt_max) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage is not reset; only entries between rptr and wptr are ever read.
    always_ff @(posedge clk) begin
        if (a_ok) mem[wptr] <= bus.wr_a_data;
        if (b_ok) mem[wptr + AW'(a_ok)] <= bus.wr_b_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
            done_q   <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= bus.tx_done;
            tx_en  <= (state_nx == SEND);
            wptr   <= wptr + AW'(a_ok) + AW'(b_ok);
            level  <= level + LW'(a_ok) + LW'(b_ok) - LW'(pop);
            if (pop) begin
                tx_data <= mem[rptr];
                rptr    <= rptr + AW'(1);
            end
            if (state == SEND)
                cnt <= '0;
            else if (state == WAIT && !done_rise && !cnt_max)
                cnt <= cnt + CW'(1);
            // A new event in the same cycle as the clear leaves the flag set.
            overflow <= (overflow && !bus.clr_ovf) || drop;
            timeout  <= (timeout && !bus.clr_ovf) || tmo_hit;
        end
    end

    assign bus.tx_data  = tx_data;
    assign bus.tx_en    = tx_en;
    assign bus.level    = level;
    assign bus.empty    = (level == '0);
    assign bus.full     = (level == LW'(DEPTH));
    assign bus.overflow = overflow;
    assign bus.timeout  = timeout;
endmodule
